xyolo_write: RTL and testbench
==============================

Name: xyolo_write

Overview:
- Write-side companion of the YOLO functional unit: consumes the sparse result stream the unit emits on its flow output (one valid word per accumulation period, optionally decimated by max-pooling) and turns it into a memory write port (address, data, write enable).
- Sits between a YOLO unit output and a Versat data-memory write port.
- Has its own delay/period/iteration sequencer so it can be aligned with the producer's pipeline latency.

Parameters:
- DATA_W, 32, width of result words and memory data.
- ADDR_W, 10, memory address width; also the iteration and line counter width.
- PERIOD_W, 10, width of period and delay counters.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  start pulse; sampled only in IDLE.
- flow_in  input  DATA_W  result word from the YOLO unit.
- start_addr  input  ADDR_W  first write address.
- incr  input  ADDR_W  address step per write.
- line_len  input  ADDR_W  writes per output line; 0 means no line jump.
- shift  input  ADDR_W  extra two's-complement address offset added after the last write of each line.
- iterations  input  ADDR_W  number of result events (pre-decimation).
- period  input  PERIOD_W  cycles between result events.
- delay  input  PERIOD_W  cycles from run to the first period start.
- decim  input  2  write one of every 2^decim events (0 means every event; 2 means 2x2 maxpool).
- mem_addr  output  ADDR_W  write address.
- mem_data  output  DATA_W  write data.
- mem_we  output  1  write enable.
- busy  output  1  high from DELAY through DONE.
- done  output  1  one-cycle pulse at completion.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - mem_addr=0, mem_data=0, mem_we=0, busy=0, done=0.
  - All counters are cleared.
  - Reset mid-operation aborts immediately; no write is issued.
- Configuration inputs are sampled and held internally on the run acceptance cycle; later changes are ignored until the next run.
- States:
  - IDLE: run=1 with iterations!=0 and period!=0 goes to DELAY, or directly to RUN if delay=0. run=1 with iterations=0 or period=0 is ignored; no done pulse is issued.
  - DELAY: a down-counter loaded with delay; go to RUN on the cycle the counter reaches 1, so DELAY lasts exactly delay cycles.
  - RUN:
    - pcnt counts 0..period-1 and wraps.
    - The cycle with pcnt==period-1 is an event cycle.
    - Each event increments ecnt mod 2^decim and icnt.
    - The event with icnt==iterations-1 goes to DONE.
  - DONE: lasts 1 cycle with done=1, then returns to IDLE.
- busy=1 in DELAY, RUN and DONE.
- run asserted while busy is ignored.
- Write rule:
  - On an event cycle with ecnt==2^decim-1, flow_in is registered into mem_data.
  - mem_addr is set to the current write address and mem_we=1 on the next cycle. Latency is 1 cycle; mem_we is high for exactly 1 cycle.
  - mem_data and mem_addr hold their values when mem_we=0.
  - The final write of a job occurs in the DONE cycle.
- Address generation:
  - waddr is loaded with start_addr at run acceptance.
  - After each write: lcnt increments. If line_len!=0 and lcnt reaches line_len, then waddr += incr+shift and lcnt=0; otherwise waddr += incr.
  - Arithmetic is modulo 2^ADDR_W (wrap-around, no saturation).
- Partial decimation group: if iterations is not a multiple of 2^decim, the trailing events produce no write.
- period=1: every RUN cycle is an event; writes may be back to back.

Test Plan:
- Basic: start_addr=0x10, incr=1, line_len=0, iterations=4, period=3, delay=2, decim=0; flow_in=cycle count -> 4 writes to 0x10..0x13. The first mem_we is 5 cycles after run (2 delay + 3 period). Writes are spaced 3 cycles. done pulses with the 4th mem_we.
- Maxpool decimation: decim=2, iterations=8, period=2, incr=1 -> exactly 2 writes, at start_addr and start_addr+1. Data equals flow_in at event cycles 4 and 8.
- Line jump: line_len=3, incr=1, shift=5, start_addr=0, iterations=6, period=1, decim=0 -> addresses 0,1,2,8,9,10 on consecutive cycles.
- Edge config: run with iterations=0 -> no busy, no done, no write. Then period=1, delay=0, iterations=1 -> busy the cycle after run, one write, done pulse.
- Wrap and ignore:
  - ADDR_W=10, start_addr=0x3FE, incr=1, iterations=3 -> addresses 0x3FE, 0x3FF, 0x000.
  - A second run pulse mid-job has no effect.
- Async reset: assert rst_n=0 between two event cycles of a 4-iteration job -> outputs zero immediately, and no further mem_we. A new run after release starts cleanly from start_addr.

Source files
------------

// File: rtl/xyolo_write_if.sv
// Bundles the YOLO result stream, job configuration and memory write port of xyolo_write.
interface xyolo_write_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int PERIOD_W = 10
);
  logic                run;
  logic [DATA_W-1:0]   flow_in;
  logic [ADDR_W-1:0]   start_addr;
  logic [ADDR_W-1:0]   incr;
  logic [ADDR_W-1:0]   line_len;
  logic [ADDR_W-1:0]   shift;
  logic [ADDR_W-1:0]   iterations;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] delay;
  logic [1:0]          decim;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_data;
  logic                mem_we;
  logic                busy;
  logic                done;

  modport master (
    output run, flow_in, start_addr, incr, line_len, shift, iterations, period, delay, decim,
    input  mem_addr, mem_data, mem_we, busy, done
  );

  modport slave (
    input  run, flow_in, start_addr, incr, line_len, shift, iterations, period, delay, decim,
    output mem_addr, mem_data, mem_we, busy, done
  );
endinterface

// File: rtl/xyolo_write.sv
// Turns the sparse YOLO result stream into memory writes (address/data/we) via a delay/period/iteration sequencer.
// Latency: one cycle from the selected event cycle to mem_we; no backpressure, each write is issued exactly once.
module xyolo_write #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int PERIOD_W = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  xyolo_write_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] dcnt_q, dcnt_d;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
  logic [ADDR_W-1:0]   icnt_q, icnt_d;
  logic [ADDR_W-1:0]   lcnt_q, lcnt_d;
  logic [2:0]          ecnt_q, ecnt_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [ADDR_W-1:0]   incr_q, incr_d;
  logic [ADDR_W-1:0]   line_len_q, line_len_d;
  logic [ADDR_W-1:0]   shift_q, shift_d;
  logic [ADDR_W-1:0]   iter_q, iter_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [1:0]          decim_q, decim_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                mem_we_q, mem_we_d;

  logic                evt;
  logic                wr;
  logic [2:0]          dmask;

  // Decimation group mask: 2^decim - 1
  assign dmask = 3'b111 >> (2'd3 - decim_q);
  assign evt   = (state_q == S_RUN) && (pcnt_q == period_q - PERIOD_W'(1));
  assign wr    = evt && (ecnt_q == dmask);

  always_comb begin
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    pcnt_d     = pcnt_q;
    icnt_d     = icnt_q;
    lcnt_d     = lcnt_q;
    ecnt_d     = ecnt_q;
    waddr_d    = waddr_q;
    incr_d     = incr_q;
    line_len_d = line_len_q;
    shift_d    = shift_q;
    iter_d     = iter_q;
    period_d   = period_q;
    decim_d    = decim_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.run && (bus.iterations != '0) && (bus.period != '0)) begin
          incr_d     = bus.incr;
          line_len_d = bus.line_len;
          shift_d    = bus.shift;
          iter_d     = bus.iterations;
          period_d   = bus.period;
          decim_d    = bus.decim;
          waddr_d    = bus.start_addr;
          dcnt_d     = bus.delay;
          pcnt_d     = '0;
          icnt_d     = '0;
          lcnt_d     = '0;
          ecnt_d     = '0;
          state_d    = (bus.delay == '0) ? S_RUN : S_DELAY;
        end
      end
      S_DELAY: begin
        if (dcnt_q == PERIOD_W'(1)) begin
          state_d = S_RUN;
        end else begin
          dcnt_d = dcnt_q - PERIOD_W'(1);
        end
      end
      S_RUN: begin
        pcnt_d = evt ? '0 : pcnt_q + PERIOD_W'(1);
        if (evt) begin
          icnt_d = icnt_q + ADDR_W'(1);
          ecnt_d = (ecnt_q + 3'd1) & dmask;
          if (icnt_q == iter_q - ADDR_W'(1)) begin
            state_d = S_DONE;
          end
        end
        if (wr) begin
          mem_we_d   = 1'b1;
          mem_addr_d = waddr_q;
          mem_data_d = bus.flow_in;
          // The line jump replaces the plain step after the last write of a line
          if ((line_len_q != '0) && (lcnt_q + ADDR_W'(1) == line_len_q)) begin
            waddr_d = waddr_q + incr_q + shift_q;
            lcnt_d  = '0;
          end else begin
            waddr_d = waddr_q + incr_q;
            lcnt_d  = lcnt_q + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      dcnt_q     <= '0;
      pcnt_q     <= '0;
      icnt_q     <= '0;
      lcnt_q     <= '0;
      ecnt_q     <= '0;
      waddr_q    <= '0;
      incr_q     <= '0;
      line_len_q <= '0;
      shift_q    <= '0;
      iter_q     <= '0;
      period_q   <= '0;
      decim_q    <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      pcnt_q     <= pcnt_d;
      icnt_q     <= icnt_d;
      lcnt_q     <= lcnt_d;
      ecnt_q     <= ecnt_d;
      waddr_q    <= waddr_d;
      incr_q     <= incr_d;
      line_len_q <= line_len_d;
      shift_q    <= shift_d;
      iter_q     <= iter_d;
      period_q   <= period_d;
      decim_q    <= decim_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);

endmodule

// File: tb/tb_xyolo_write.sv
// Randomized bench for xyolo_write: per-cycle checks against a job-level model of the event/write schedule.
module tb_xyolo_write;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int PW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xyolo_write_if #(.DATA_W(DW), .ADDR_W(AW), .PERIOD_W(PW)) bus ();

  xyolo_write #(.DATA_W(DW), .ADDR_W(AW), .PERIOD_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic scramble_cfg();
    bus.start_addr = AW'($urandom);
    bus.incr       = AW'($urandom);
    bus.line_len   = AW'($urandom);
    bus.shift      = AW'($urandom);
    bus.iterations = AW'($urandom_range(1, 20));
    bus.period     = PW'($urandom_range(1, 5));
    bus.delay      = PW'($urandom_range(0, 5));
    bus.decim      = 2'($urandom);
  endtask

  task automatic check_outputs(input string tag, input bit exp_we, input bit exp_done, input bit exp_busy);
    chk({tag, ".we"},   bus.mem_we,   exp_we);
    chk({tag, ".addr"}, bus.mem_addr, last_addr);
    chk({tag, ".data"}, bus.mem_data, last_data);
    chk({tag, ".done"}, bus.done,     exp_done);
    chk({tag, ".busy"}, bus.busy,     exp_busy);
  endtask

  // Job model: event k (1-based) lands on edge delay + k*period after acceptance;
  // every 2^decim-th event writes flow_in sampled on that edge.
  task automatic run_job(input logic [AW-1:0] sa, input logic [AW-1:0] inc, input logic [AW-1:0] ll,
                         input logic [AW-1:0] sh, input logic [AW-1:0] it, input logic [PW-1:0] per,
                         input logic [PW-1:0] dl, input logic [1:0] dc, input bit mid_run);
    int d, pi, di, ii, last, q;
    bit exp_we;
    logic [AW-1:0] wa, lc;
    logic [DW-1:0] fv;
    d  = 1 << dc;
    pi = int'(per);
    di = int'(dl);
    ii = int'(it);
    last = di + ii * pi;
    wa = sa;
    lc = '0;
    @(negedge clk);
    bus.start_addr = sa; bus.incr = inc; bus.line_len = ll; bus.shift = sh;
    bus.iterations = it; bus.period = per; bus.delay = dl; bus.decim = dc;
    bus.run = 1'b1;
    bus.flow_in = $urandom;
    @(posedge clk); #1;
    bus.run = 1'b0;
    scramble_cfg();
    check_outputs("accept", 1'b0, 1'b0, 1'b1);
    for (int n = 1; n <= last + 1; n++) begin
      @(negedge clk);
      fv = $urandom;
      bus.flow_in = fv;
      bus.run = (mid_run && n == 2 && last >= 2);
      @(posedge clk); #1;
      exp_we = 1'b0;
      if (n > di && (n - di) % pi == 0) begin
        q = (n - di) / pi;
        if (q <= ii && q % d == 0) exp_we = 1'b1;
      end
      if (exp_we) begin
        last_addr = wa;
        last_data = fv;
        lc = lc + AW'(1);
        if (ll != '0 && lc == ll) begin
          wa = wa + inc + sh;
          lc = '0;
        end else begin
          wa = wa + inc;
        end
      end
      check_outputs("job", exp_we, (n == last), (n <= last));
    end
    bus.run = 1'b0;
  endtask

  task automatic ignored_run(input logic [AW-1:0] it, input logic [PW-1:0] per);
    @(negedge clk);
    bus.iterations = it; bus.period = per; bus.delay = PW'(0); bus.decim = 2'd0;
    bus.run = 1'b1;
    @(posedge clk); #1;
    bus.run = 1'b0;
    for (int n = 0; n < 4; n++) begin
      check_outputs("ignored", 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.run = 1'b0;
    bus.flow_in = '0;
    bus.start_addr = '0; bus.incr = '0; bus.line_len = '0; bus.shift = '0;
    bus.iterations = '0; bus.period = '0; bus.delay = '0; bus.decim = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic, maxpool, line jump, single-shot, wrap with a mid-job run pulse
    run_job(AW'(16'h10), AW'(1), AW'(0), AW'(0), AW'(4), PW'(3), PW'(2), 2'd0, 1'b0);
    run_job(AW'(16'h40), AW'(1), AW'(0), AW'(0), AW'(8), PW'(2), PW'(1), 2'd2, 1'b0);
    run_job(AW'(0), AW'(1), AW'(3), AW'(5), AW'(6), PW'(1), PW'(0), 2'd0, 1'b0);
    ignored_run(AW'(0), PW'(3));
    ignored_run(AW'(5), PW'(0));
    run_job(AW'(16'h55), AW'(7), AW'(0), AW'(0), AW'(1), PW'(1), PW'(0), 2'd0, 1'b0);
    run_job(AW'(16'h3FE), AW'(1), AW'(0), AW'(0), AW'(3), PW'(2), PW'(1), 2'd0, 1'b1);
    // partial decimation group: 5 events, groups of 2 -> 2 writes
    run_job(AW'(16'h100), AW'(2), AW'(0), AW'(0), AW'(5), PW'(2), PW'(0), 2'd1, 1'b0);
    // negative shift via two's complement
    run_job(AW'(16'h200), AW'(4), AW'(2), AW'(16'h3F8), AW'(6), PW'(1), PW'(3), 2'd0, 1'b1);

    for (int j = 0; j < 12; j++) begin
      run_job(AW'($urandom), AW'($urandom), AW'($urandom_range(0, 4)), AW'($urandom),
              AW'($urandom_range(1, 12)), PW'($urandom_range(1, 4)), PW'($urandom_range(0, 4)),
              2'($urandom), 1'($urandom));
    end

    // async reset between event cycles of a 4-iteration job
    @(negedge clk);
    bus.start_addr = AW'(16'h20); bus.incr = AW'(2); bus.line_len = '0; bus.shift = '0;
    bus.iterations = AW'(4); bus.period = PW'(3); bus.delay = PW'(1); bus.decim = 2'd0;
    bus.run = 1'b1;
    @(posedge clk); #1;
    bus.run = 1'b0;
    repeat (5) begin
      @(negedge clk);
      bus.flow_in = $urandom;
      @(posedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    last_addr = '0;
    last_data = '0;
    check_outputs("arst", 1'b0, 1'b0, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
      check_outputs("arst_hold", 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_job(AW'(16'h20), AW'(2), AW'(0), AW'(0), AW'(4), PW'(3), PW'(1), 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
